// File: rtl/uart_console_bridge.sv
// Bus master for the iob_uart register port: initialises the UART, then alternates
// RX/TX readiness polling, moving bytes into an RX FIFO and out of a TX holding register.
module uart_console_bridge #(
    parameter int unsigned ADDR_W       = 3,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned A_SOFTRESET  = 0,
    parameter int unsigned A_DIV        = 1,
    parameter int unsigned A_TXDATA     = 2,
    parameter int unsigned A_TXEN       = 3,
    parameter int unsigned A_TXREADY    = 4,
    parameter int unsigned A_RXDATA     = 5,
    parameter int unsigned A_RXEN       = 6,
    parameter int unsigned A_RXREADY    = 7,
    parameter int unsigned DIV_VALUE    = 868,
    parameter int unsigned RX_DEPTH_LOG = 3,
    parameter int unsigned TIMEOUT      = 1023
) (
    input  logic              clk,
    input  logic              rst,
    output logic              uart_valid,
    output logic [ADDR_W-1:0] uart_addr,
    output logic [DATA_W-1:0] uart_wdata,
    output logic [3:0]        uart_wstrb,
    input  logic [DATA_W-1:0] uart_rdata,
    input  logic              uart_ready,
    input  logic              tx_valid,
    input  logic [7:0]        tx_data,
    output logic              tx_ready,
    output logic              rx_valid,
    output logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              init_done,
    output logic              bus_err
);

    localparam int unsigned RX_DEPTH = 1 << RX_DEPTH_LOG;
    localparam logic [15:0] TMR_LAST = 16'(TIMEOUT - 1);
    localparam logic [RX_DEPTH_LOG:0] PTR_ONE = 1;

    typedef enum logic [3:0] {
        I_SRST1, I_SRST0, I_DIV, I_TXEN, I_RXEN, P_RX, R_RX, P_TX, W_TX
    } state_t;

    state_t              state_q, state_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [15:0]         tmr_q, tmr_d;
    logic                init_done_q, init_done_d;
    logic                bus_err_q, bus_err_d;
    logic                hold_full_q, hold_full_d;
    logic [7:0]          hold_data_q, hold_data_d;
    logic                tx_ready_q, tx_ready_d;
    logic [RX_DEPTH_LOG:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]          mem_q [RX_DEPTH];

    logic [RX_DEPTH_LOG:0] fifo_count;
    logic                fifo_full, fifo_empty, pop;
    logic                push;
    logic [7:0]          push_data;
    logic                done, fail, ok;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic                req_write;
    logic                rdata_unused;

    assign fifo_count   = wptr_q - rptr_q;
    assign fifo_full    = fifo_count[RX_DEPTH_LOG];
    assign fifo_empty   = (wptr_q == rptr_q);
    assign pop          = rx_ready & ~fifo_empty;
    assign rdata_unused = ^uart_rdata[DATA_W-1:8];

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        req_write = 1'b0;
        case (state_q)
            I_SRST1: begin req_addr = ADDR_W'(A_SOFTRESET); req_wdata = DATA_W'(1); req_write = 1'b1; end
            I_SRST0: begin req_addr = ADDR_W'(A_SOFTRESET); req_write = 1'b1; end
            I_DIV:   begin req_addr = ADDR_W'(A_DIV); req_wdata = DATA_W'(DIV_VALUE); req_write = 1'b1; end
            I_TXEN:  begin req_addr = ADDR_W'(A_TXEN); req_wdata = DATA_W'(1); req_write = 1'b1; end
            I_RXEN:  begin req_addr = ADDR_W'(A_RXEN); req_wdata = DATA_W'(1); req_write = 1'b1; end
            P_RX:    req_addr = ADDR_W'(A_RXREADY);
            R_RX:    req_addr = ADDR_W'(A_RXDATA);
            P_TX:    req_addr = ADDR_W'(A_TXREADY);
            W_TX:    begin req_addr = ADDR_W'(A_TXDATA); req_wdata = DATA_W'(hold_data_q); req_write = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        tmr_d       = tmr_q;
        init_done_d = init_done_q;
        bus_err_d   = bus_err_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        push        = 1'b0;
        push_data   = uart_rdata[7:0];
        done        = valid_q & uart_ready;
        fail        = valid_q & ~uart_ready & (tmr_q == TMR_LAST);
        ok          = done & uart_rdata[0];

        if (!valid_q) begin
            // Skipped polls move straight to the other poll state without a bus cycle.
            if (state_q == P_RX && fifo_full) begin
                state_d = P_TX;
            end else if (state_q == P_TX && !hold_full_q) begin
                state_d = P_RX;
            end else begin
                valid_d = 1'b1;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                wstrb_d = req_write ? 4'b0001 : 4'b0000;
                tmr_d   = '0;
            end
        end else if (done || fail) begin
            valid_d = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
            wstrb_d = '0;
            if (fail) bus_err_d = 1'b1;
            case (state_q)
                I_SRST1: state_d = I_SRST0;
                I_SRST0: state_d = I_DIV;
                I_DIV:   state_d = I_TXEN;
                I_TXEN:  state_d = I_RXEN;
                I_RXEN:  begin state_d = P_RX; init_done_d = 1'b1; end
                P_RX:    state_d = ok ? R_RX : P_TX;
                R_RX:    begin push = done; state_d = P_TX; end
                P_TX:    state_d = ok ? W_TX : P_RX;
                W_TX:    begin if (done) hold_full_d = 1'b0; state_d = P_RX; end
                default: state_d = I_SRST1;
            endcase
        end else begin
            tmr_d = tmr_q + 16'd1;
        end

        if (tx_valid && tx_ready_q) begin
            hold_full_d = 1'b1;
            hold_data_d = tx_data;
        end
        tx_ready_d = init_done_d & ~hold_full_d;
        wptr_d     = push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d     = pop ? rptr_q + PTR_ONE : rptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= I_SRST1;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            tmr_q       <= '0;
            init_done_q <= 1'b0;
            bus_err_q   <= 1'b0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            tx_ready_q  <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            for (int unsigned i = 0; i < RX_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            tmr_q       <= tmr_d;
            init_done_q <= init_done_d;
            bus_err_q   <= bus_err_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            tx_ready_q  <= tx_ready_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            if (push) mem_q[wptr_q[RX_DEPTH_LOG-1:0]] <= push_data;
        end
    end

    assign uart_valid = valid_q;
    assign uart_addr  = addr_q;
    assign uart_wdata = wdata_q;
    assign uart_wstrb = wstrb_q;
    assign tx_ready   = tx_ready_q;
    assign rx_valid   = ~fifo_empty;
    assign rx_data    = mem_q[rptr_q[RX_DEPTH_LOG-1:0]];
    assign init_done  = init_done_q;
    assign bus_err    = bus_err_q;

endmodule
